// File: rtl/rsa_feeder_if.sv
// rsa_feeder_if
//   Bundles the operand-memory read ports and the array load stream driven
//   by rsa_feeder.
//   master : feeder side  (drives read strobes/addresses and the beat streams)
//   slave  : memory/array side (returns read data, consumes the beats)
//
// Handshake: the stream is valid-only. A beat transfers on every rising edge
// where *_val is high; the array's input FIFOs always accept, so there is no
// ready. *_data is forced to 0 whenever its valid is low. Memory read data
// is returned exactly one cycle after the matching *_rd_en.
interface rsa_feeder_if #(
    parameter int IN_LEN = 8,
    parameter int MEM_AW = 8
);
    logic              a_rd_en;
    logic [MEM_AW-1:0] a_rd_addr;
    logic [IN_LEN-1:0] a_rd_data;
    logic              b_rd_en;
    logic [MEM_AW-1:0] b_rd_addr;
    logic [IN_LEN-1:0] b_rd_data;
    logic              Xin_val;
    logic [IN_LEN-1:0] Xin_data;
    logic              Yin_val;
    logic [IN_LEN-1:0] Yin_data;
    logic              SA_start;

    modport master (
        output a_rd_en, a_rd_addr, b_rd_en, b_rd_addr,
        input  a_rd_data, b_rd_data,
        output Xin_val, Xin_data, Yin_val, Yin_data, SA_start
    );

    modport slave (
        input  a_rd_en, a_rd_addr, b_rd_en, b_rd_addr,
        output a_rd_data, b_rd_data,
        input  Xin_val, Xin_data, Yin_val, Yin_data, SA_start
    );
endinterface

// File: rtl/rsa_feeder.sv
// rsa_feeder
//   Streams operand matrix A (X x N, row order) and operand matrix B
//   (N x Y, column order) out of two synchronous single-port memories onto
//   the systolic array's Xin/Yin beat streams, then pulses SA_start.
//
// Ports
//   clk, sys_rst        : clock, synchronous active-high reset
//   start               : request pulse, honoured only in IDLE
//   a_base, b_base      : operand base addresses, captured on acceptance
//   bus (master)        : memory read ports + Xin/Yin streams + SA_start
//   busy                : high from acceptance until the cycle after SA_start
//   done                : one-cycle pulse coincident with SA_start
//   dbg_state_o         : current FSM state (0 IDLE, 1 STREAM, 2 FLUSH, 3 FIRE)
//
// Build option
//   RSA_FEEDER_BTRANS_EN : B is stored transposed (Y x N row-major), so its
//                          addresses become a linear increment. Beat order
//                          on Yin is unchanged.
module rsa_feeder #(
    parameter int X      = 3,
    parameter int N      = 4,
    parameter int Y      = 3,
    parameter int IN_LEN = 8,
    parameter int MEM_AW = 8
) (
    input  logic              clk,
    input  logic              sys_rst,
    input  logic              start,
    input  logic [MEM_AW-1:0] a_base,
    input  logic [MEM_AW-1:0] b_base,
    rsa_feeder_if.master      bus,
    output logic              busy,
    output logic              done,
    output logic [1:0]        dbg_state_o
);
    localparam int A_BEATS = X * N;
    localparam int A_CW    = (A_BEATS > 1) ? $clog2(A_BEATS) : 1;
    localparam int KW      = (N > 1) ? $clog2(N) : 1;
    localparam int JW      = (Y > 1) ? $clog2(Y) : 1;
    localparam logic [A_CW-1:0] A_LAST = A_CW'(A_BEATS - 1);
    localparam logic [KW-1:0]   K_LAST = KW'(N - 1);
    localparam logic [JW-1:0]   J_LAST = JW'(Y - 1);
`ifdef RSA_FEEDER_BTRANS_EN
    // Column j of B is a contiguous run of N words.
    localparam logic [MEM_AW-1:0] B_STEP     = MEM_AW'(1);
    localparam int                COL_STRIDE = N;
`else
    // Column j of B is strided by Y; the next column starts one word later.
    localparam logic [MEM_AW-1:0] B_STEP     = MEM_AW'(Y);
    localparam int                COL_STRIDE = 1;
`endif

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_FLUSH, S_FIRE} state_t;

    state_t            state_q, state_d;
    logic [A_CW-1:0]   a_cnt_q, a_cnt_d;
    logic [MEM_AW-1:0] a_addr_q, a_addr_d;
    logic              a_act_q, a_act_d;
    logic [KW-1:0]     b_k_q, b_k_d;
    logic [JW-1:0]     b_j_q, b_j_d;
    logic [MEM_AW-1:0] b_addr_q, b_addr_d;
    logic [MEM_AW-1:0] b_base_q, b_base_d;
    logic              b_act_q, b_act_d;
    logic              xval_q, yval_q;
    logic              a_rd_en, b_rd_en;
    logic [MEM_AW-1:0] b_col_next;

    // First address of the column after the current one.
    assign b_col_next = b_base_q + MEM_AW'((32'(b_j_q) + 1) * COL_STRIDE);

    always_comb begin
        state_d  = state_q;
        a_cnt_d  = a_cnt_q;
        a_addr_d = a_addr_q;
        a_act_d  = a_act_q;
        b_k_d    = b_k_q;
        b_j_d    = b_j_q;
        b_addr_d = b_addr_q;
        b_base_d = b_base_q;
        b_act_d  = b_act_q;
        a_rd_en  = 1'b0;
        b_rd_en  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_STREAM;
                    a_cnt_d  = '0;
                    a_addr_d = a_base;
                    a_act_d  = 1'b1;
                    b_k_d    = '0;
                    b_j_d    = '0;
                    b_addr_d = b_base;
                    b_base_d = b_base;
                    b_act_d  = 1'b1;
                end
            end
            S_STREAM: begin
                a_rd_en = a_act_q;
                b_rd_en = b_act_q;
                if (a_act_q) begin
                    a_addr_d = a_addr_q + MEM_AW'(1);
                    if (a_cnt_q == A_LAST) a_act_d = 1'b0;
                    else                   a_cnt_d = a_cnt_q + A_CW'(1);
                end
                if (b_act_q) begin
                    if (b_k_q == K_LAST) begin
                        b_k_d = '0;
                        if (b_j_q == J_LAST) begin
                            b_act_d = 1'b0;
                        end else begin
                            b_j_d    = b_j_q + JW'(1);
                            b_addr_d = b_col_next;
                        end
                    end else begin
                        b_k_d    = b_k_q + KW'(1);
                        b_addr_d = b_addr_q + B_STEP;
                    end
                end
                // Leave as soon as this cycle issued the last read of both streams.
                if (!a_act_d && !b_act_d) state_d = S_FLUSH;
            end
            S_FLUSH: state_d = S_FIRE;
            S_FIRE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            state_q  <= S_IDLE;
            a_cnt_q  <= '0;
            a_addr_q <= '0;
            a_act_q  <= 1'b0;
            b_k_q    <= '0;
            b_j_q    <= '0;
            b_addr_q <= '0;
            b_base_q <= '0;
            b_act_q  <= 1'b0;
            xval_q   <= 1'b0;
            yval_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_cnt_q  <= a_cnt_d;
            a_addr_q <= a_addr_d;
            a_act_q  <= a_act_d;
            b_k_q    <= b_k_d;
            b_j_q    <= b_j_d;
            b_addr_q <= b_addr_d;
            b_base_q <= b_base_d;
            b_act_q  <= b_act_d;
            // Valid tracks the strobe by one cycle, matching memory latency.
            xval_q   <= a_rd_en;
            yval_q   <= b_rd_en;
        end
    end

    assign bus.a_rd_en   = a_rd_en;
    assign bus.b_rd_en   = b_rd_en;
    assign bus.a_rd_addr = a_rd_en ? a_addr_q : '0;
    assign bus.b_rd_addr = b_rd_en ? b_addr_q : '0;
    assign bus.Xin_val   = xval_q;
    assign bus.Yin_val   = yval_q;
    assign bus.Xin_data  = xval_q ? bus.a_rd_data : '0;
    assign bus.Yin_data  = yval_q ? bus.b_rd_data : '0;
    assign bus.SA_start  = (state_q == S_FIRE);
    assign done          = (state_q == S_FIRE);
    assign busy          = (state_q != S_IDLE);
    assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_rsa_feeder.sv
module tb_rsa_feeder;
  localparam int X = 3;
  localparam int N = 4;
  localparam int Y = 3;
  localparam int M = 12;       // max(X,Y)*N beats
  localparam int FIRE_N = 14;  // cycle of SA_start

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic sys_rst = 1'b1;
  logic start = 1'b0;
  logic start2 = 1'b0;
  logic [7:0] a_base = 8'h00;
  logic [7:0] b_base = 8'h00;
  logic busy, done, busy2, done2;
  logic [1:0] dbg_state, dbg_state2;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rsa_feeder_if #(.IN_LEN(8), .MEM_AW(8)) bus ();
  rsa_feeder_if #(.IN_LEN(8), .MEM_AW(8)) bus2 ();

  rsa_feeder #(.X(X), .N(N), .Y(Y), .IN_LEN(8), .MEM_AW(8)) u_dut (
    .clk(clk), .sys_rst(sys_rst), .start(start), .a_base(a_base), .b_base(b_base),
    .bus(bus), .busy(busy), .done(done), .dbg_state_o(dbg_state)
  );

  rsa_feeder #(.X(3), .N(4), .Y(2), .IN_LEN(8), .MEM_AW(8)) u_dut2 (
    .clk(clk), .sys_rst(sys_rst), .start(start2), .a_base(a_base), .b_base(b_base),
    .bus(bus2), .busy(busy2), .done(done2), .dbg_state_o(dbg_state2)
  );

  // ---------------- operand memories ----------------
  logic [7:0] a_mem [256];
  logic [7:0] b_mem [256];

  always @(posedge clk) begin
    if (bus.a_rd_en)  bus.a_rd_data  <= a_mem[bus.a_rd_addr];
    if (bus.b_rd_en)  bus.b_rd_data  <= b_mem[bus.b_rd_addr];
    if (bus2.a_rd_en) bus2.a_rd_data <= a_mem[bus2.a_rd_addr];
    if (bus2.b_rd_en) bus2.b_rd_data <= b_mem[bus2.b_rd_addr];
  end

  // ---------------- scoreboard ----------------
  // entry = {cycle[31:0], value[15:0]}
  logic [47:0] xq[$];
  logic [47:0] yq[$];
  logic [47:0] aq[$];
  logic [47:0] bq[$];
  int fq[$];
  int busy_lo = -1;
  int busy_hi = -2;
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexp(input string name);
    checks++;
    failures++;
    $display("FAIL %s: unexpected event at cyc %0d", name, cyc);
  endtask

  // Layout A linearly from ab with A[t]=t+1, B[k][j]=0x80+k*Y+j.
  task automatic fill(input logic [7:0] ab, input logic [7:0] bb);
    logic [7:0] ad;
    for (int t = 0; t < X * N; t++) begin
      ad = ab + 8'(t);
      a_mem[ad] = 8'(t + 1);
    end
    for (int k = 0; k < N; k++) begin
      for (int j = 0; j < Y; j++) begin
`ifdef RSA_FEEDER_BTRANS_EN
        ad = bb + 8'(j * N + k);
`else
        ad = bb + 8'(k * Y + j);
`endif
        b_mem[ad] = 8'(8'h80 + k * Y + j);
      end
    end
  endtask

  // Push the expected schedule for a transaction accepted at edge c0,
  // keeping only events up to cycle 'limit'.
  task automatic expect_txn(input int c0, input logic [7:0] ab, input logic [7:0] bb,
                            input int limit, input bit fire);
    logic [7:0] ad;
    int n, t;
    for (int i = 0; i < X * N; i++) begin
      n = i + 1;
      ad = ab + 8'(i);
      if (n <= limit) aq.push_back({32'(c0 + n), 8'h00, ad});
      if (n + 1 <= limit) xq.push_back({32'(c0 + n + 1), 8'h00, 8'(i + 1)});
    end
    for (int j = 0; j < Y; j++) begin
      for (int k = 0; k < N; k++) begin
        t = j * N + k;
        n = t + 1;
`ifdef RSA_FEEDER_BTRANS_EN
        ad = bb + 8'(t);
`else
        ad = bb + 8'(k * Y + j);
`endif
        if (n <= limit) bq.push_back({32'(c0 + n), 8'h00, ad});
        if (n + 1 <= limit) yq.push_back({32'(c0 + n + 1), 8'h00, 8'(8'h80 + k * Y + j)});
      end
    end
    if (fire) fq.push_back(c0 + FIRE_N);
    busy_lo = c0 + 1;
    busy_hi = fire ? c0 + FIRE_N : c0 + limit;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [47:0] e;
    int f;
    if (!sys_rst || cyc > 4) begin
      if (bus.a_rd_en) begin
        if (aq.size() == 0) unexp("a_rd");
        else begin
          e = aq.pop_front();
          chk("a_rd_cycle", cyc, e[47:16]);
          chk("a_rd_addr", 32'(bus.a_rd_addr), 32'(e[15:0]));
        end
      end
      if (bus.b_rd_en) begin
        if (bq.size() == 0) unexp("b_rd");
        else begin
          e = bq.pop_front();
          chk("b_rd_cycle", cyc, e[47:16]);
          chk("b_rd_addr", 32'(bus.b_rd_addr), 32'(e[15:0]));
        end
      end
      if (bus.Xin_val) begin
        if (xq.size() == 0) unexp("xin");
        else begin
          e = xq.pop_front();
          chk("xin_cycle", cyc, e[47:16]);
          chk("xin_data", 32'(bus.Xin_data), 32'(e[15:0]));
        end
      end else if (bus.Xin_data != 8'h00) chk("xin_zero", 32'(bus.Xin_data), 0);
      if (bus.Yin_val) begin
        if (yq.size() == 0) unexp("yin");
        else begin
          e = yq.pop_front();
          chk("yin_cycle", cyc, e[47:16]);
          chk("yin_data", 32'(bus.Yin_data), 32'(e[15:0]));
        end
      end else if (bus.Yin_data != 8'h00) chk("yin_zero", 32'(bus.Yin_data), 0);
      if (bus.SA_start) begin
        if (fq.size() == 0) unexp("sa_start");
        else begin
          f = fq.pop_front();
          chk("sa_start_cycle", cyc, 32'(f));
        end
      end
      if (done !== bus.SA_start) chk("done_eq_sa", 32'(done), 32'(bus.SA_start));
      chk("busy", 32'(busy), 32'(cyc >= busy_lo && cyc <= busy_hi));
    end
  end

  task automatic chk_drain();
    chk("drain_a", aq.size(), 0);
    chk("drain_b", bq.size(), 0);
    chk("drain_x", xq.size(), 0);
    chk("drain_y", yq.size(), 0);
    chk("drain_fire", fq.size(), 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_a_rd_en"}, 32'(bus.a_rd_en), 0);
    chk({tag, "_b_rd_en"}, 32'(bus.b_rd_en), 0);
    chk({tag, "_a_addr"}, 32'(bus.a_rd_addr), 0);
    chk({tag, "_b_addr"}, 32'(bus.b_rd_addr), 0);
    chk({tag, "_xval"}, 32'(bus.Xin_val), 0);
    chk({tag, "_yval"}, 32'(bus.Yin_val), 0);
    chk({tag, "_xdata"}, 32'(bus.Xin_data), 0);
    chk({tag, "_ydata"}, 32'(bus.Yin_data), 0);
    chk({tag, "_sa"}, 32'(bus.SA_start), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_state"}, 32'(dbg_state), 0);
  endtask

  // ---------------- driver ----------------
  // hold: start low again from cycle 'hold'; pulse_at: extra 1-cycle start;
  // rst_at: sys_rst high during that cycle (0 = none).
  task automatic run_txn(input logic [7:0] ab, input logic [7:0] bb, input int hold,
                         input int pulse_at, input int rst_at);
    int c0;
    @(negedge clk);
    fill(ab, bb);
    c0 = cyc;
    expect_txn(c0, ab, bb, (rst_at > 0) ? rst_at : 100, rst_at == 0);
    a_base = ab;
    b_base = bb;
    start = 1'b1;
    for (int n = 1; n <= 18; n++) begin
      @(negedge clk);
      if (n == hold) start = 1'b0;
      if (n == pulse_at) start = 1'b1;
      if (pulse_at > 0 && n == pulse_at + 1) start = 1'b0;
      if (n == rst_at) sys_rst = 1'b1;
      if (rst_at > 0 && n == rst_at + 1) begin
        sys_rst = 1'b0;
        chk_all_zero("post_rst");
      end
    end
    chk_drain();
  endtask

  initial begin
    // reset state
    sys_rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    sys_rst = 1'b0;
    repeat (2) @(negedge clk);

    // nominal: A at 0x00, B at 0x40
    run_txn(8'h00, 8'h40, 1, 0, 0);
    // address wrap on A
    run_txn(8'hFE, 8'h40, 1, 0, 0);
    // start held through the whole transaction
    run_txn(8'h00, 8'h40, FIRE_N, 0, 0);
    // stray start pulse in cycle 5
    run_txn(8'h00, 8'h40, 1, 5, 0);
    // reset in cycle 6, then a fresh nominal run
    run_txn(8'h00, 8'h40, 1, 0, 6);
    run_txn(8'h00, 8'h40, 1, 0, 0);

    // Y=2 instance: shorter B stream ends early
    begin
      int c0;
      @(negedge clk);
      c0 = cyc;
      start2 = 1'b1;
      for (int n = 1; n <= 16; n++) begin
        @(negedge clk);
        if (n == 1) start2 = 1'b0;
        chk("y2_xval", 32'(bus2.Xin_val), 32'(n >= 2 && n <= 13));
        chk("y2_yval", 32'(bus2.Yin_val), 32'(n >= 2 && n <= 9));
        chk("y2_sa", 32'(bus2.SA_start), 32'(n == 14));
        chk("y2_busy", 32'(busy2), 32'(n <= 14));
      end
      chk("y2_cycle", 32'(cyc - c0), 16);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
